// File: rtl/aes_block_uart_serializer.sv
// Transmit-side block-to-byte serializer.
// 128-bit AES blocks enter through a small block FIFO and leave as 16 bytes
// through the uart_tx start/done handshake. One block sits in the shift
// register while it is on the wire. blocks_sent_o counts completed blocks.
// frame_done_o marks the end of a block that carries the last flag.
module aes_block_uart_serializer #(
    parameter int FIFO_DEPTH = 2,   // power of 2, >= 2
    parameter bit LSB_FIRST  = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,           // synchronous, active low
    input  logic [127:0]     blk_data_i,
    input  logic             blk_last_i,
    input  logic             blk_valid_i,
    output logic             blk_ready_o,
    output logic [7:0]       uart_tx_data_o,
    output logic             uart_tx_start_o,
    input  logic             uart_tx_done_i,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic [CNT_W-1:0] blocks_sent_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    // Block FIFO: {last, data} per entry
    logic [128:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [127:0]     head_data;
    logic             head_last;

    // Serializer state
    state_t           state_q, state_d;
    logic [127:0]     shift_q, shift_d;
    logic             last_q, last_d;
    logic [3:0]       idx_q, idx_d;
    logic [7:0]       data_q, data_d;
    logic             start_q, start_d;
    logic             frame_q, frame_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_ok;

    // Ready is derived from registered occupancy only, so a same-cycle pop
    // never opens a slot for that cycle's push.
    assign fifo_full   = (occ_q == OCC_FULL);
    assign fifo_empty  = (occ_q == '0);
    assign push        = blk_valid_i && !fifo_full;
    assign pop         = (state_q == S_IDLE) && !fifo_empty;
    assign head_data   = fifo_mem[rd_ptr_q][127:0];
    assign head_last   = fifo_mem[rd_ptr_q][128];

    // A done in the start cycle cannot belong to the byte just launched.
    assign done_ok     = uart_tx_done_i && !start_q;

    assign blk_ready_o     = !fifo_full;
    assign uart_tx_data_o  = data_q;
    assign uart_tx_start_o = start_q;
    assign frame_done_o    = frame_q;
    assign blocks_sent_o   = cnt_q;
    assign busy_o          = (state_q != S_IDLE) || !fifo_empty;

    // FIFO storage write; contents need no reset since pointers gate reads
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {blk_last_i, blk_data_i};
        end
    end

    // FIFO pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    // State and registered-output update with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            state_q  <= S_IDLE;
            shift_q  <= '0;
            last_q   <= 1'b0;
            idx_q    <= '0;
            data_q   <= 8'h00;
            start_q  <= 1'b0;
            frame_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            state_q  <= state_d;
            shift_q  <= shift_d;
            last_q   <= last_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            start_q  <= start_d;
            frame_q  <= frame_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state: leave idle on a pop, return after the 16th byte completes
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (done_ok && (idx_q == 4'd15)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values: load block, step bytes, count completions
    always_comb begin
        shift_d = shift_q;
        last_d  = last_q;
        idx_d   = idx_q;
        data_d  = data_q;
        start_d = 1'b0;
        frame_d = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    shift_d = head_data;
                    last_d  = head_last;
                    idx_d   = 4'd0;
                    data_d  = LSB_FIRST ? head_data[7:0] : head_data[127:120];
                    start_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (done_ok) begin
                    if (idx_q != 4'd15) begin
                        idx_d   = idx_q + 4'd1;
                        shift_d = LSB_FIRST ? (shift_q >> 8) : (shift_q << 8);
                        data_d  = LSB_FIRST ? shift_q[15:8] : shift_q[119:112];
                        start_d = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        frame_d = last_q;
                    end
                end
            end
            default: begin
                start_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_block_uart_serializer.sv
// Directed bench for aes_block_uart_serializer: instance A is LSB-first,
// instance B is MSB-first. Inputs change on the falling edge, outputs are
// observed on the falling edge.
module tb_aes_block_uart_serializer;

    localparam logic [127:0] BLK = 128'h000102030405060708090A0B0C0D0E0F;

    logic         clk = 1'b0;
    logic         reset;

    logic [127:0] a_data, b_data;
    logic         a_last, b_last, a_valid, b_valid, a_done, b_done;
    logic         a_ready, b_ready, a_start, b_start, a_busy, b_busy, a_fd, b_fd;
    logic [7:0]   a_txd, b_txd;
    logic [15:0]  a_cnt, b_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    aes_block_uart_serializer #(.FIFO_DEPTH(2), .LSB_FIRST(1'b1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset),
        .blk_data_i(a_data), .blk_last_i(a_last), .blk_valid_i(a_valid), .blk_ready_o(a_ready),
        .uart_tx_data_o(a_txd), .uart_tx_start_o(a_start), .uart_tx_done_i(a_done),
        .busy_o(a_busy), .frame_done_o(a_fd), .blocks_sent_o(a_cnt)
    );

    aes_block_uart_serializer #(.FIFO_DEPTH(2), .LSB_FIRST(1'b0), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset),
        .blk_data_i(b_data), .blk_last_i(b_last), .blk_valid_i(b_valid), .blk_ready_o(b_ready),
        .uart_tx_data_o(b_txd), .uart_tx_start_o(b_start), .uart_tx_done_i(b_done),
        .busy_o(b_busy), .frame_done_o(b_fd), .blocks_sent_o(b_cnt)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic logic get_start(input bit sel);
        return sel ? b_start : a_start;
    endfunction
    function automatic logic [7:0] get_data(input bit sel);
        return sel ? b_txd : a_txd;
    endfunction
    function automatic logic get_fd(input bit sel);
        return sel ? b_fd : a_fd;
    endfunction
    function automatic logic [15:0] get_cnt(input bit sel);
        return sel ? b_cnt : a_cnt;
    endfunction
    function automatic logic get_ready(input bit sel);
        return sel ? b_ready : a_ready;
    endfunction

    task automatic set_done(input bit sel, input logic v);
        if (sel) b_done = v;
        else     a_done = v;
    endtask

    // Byte k of a block in wire order
    function automatic logic [7:0] exp_byte(input logic [127:0] blk, input int k, input bit lsb);
        return lsb ? blk[8*k +: 8] : blk[127-8*k -: 8];
    endfunction

    // Distinct test block: byte k (LSB first) = i*16 + k
    function automatic logic [127:0] mk(input int i);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = 8'(i * 16 + k);
        return r;
    endfunction

    task automatic push(input bit sel, input logic [127:0] d, input logic last);
        if (sel) begin b_valid = 1'b1; b_data = d; b_last = last; end
        else     begin a_valid = 1'b1; a_data = d; a_last = last; end
        chk("ready_before_push", get_ready(sel), 1'b1);
        tick();
        if (sel) b_valid = 1'b0;
        else     a_valid = 1'b0;
    endtask

    // Acts as the UART: answers each start 10 cycles later with a done pulse.
    // skip_first: the first start pulse already went by; its byte is still held.
    task automatic serve_block(input bit sel, input logic [127:0] blk, input logic last,
                               input bit lsb, input bit skip_first, input int nbytes,
                               input int exp_cnt);
        bit start_ok = 1'b1;
        bit hold_ok  = 1'b1;
        bit fd_ok    = 1'b1;
        for (int k = 0; k < nbytes; k++) begin
            logic [7:0] eb;
            eb = exp_byte(blk, k, lsb);
            if (!(skip_first && k == 0)) begin
                int guard = 0;
                while (!get_start(sel) && guard < 200) begin
                    tick();
                    guard++;
                end
                chk($sformatf("start_seen_b%0d", k), get_start(sel), 1'b1);
            end
            chk($sformatf("byte%0d", k), get_data(sel), eb);
            for (int d = 0; d < 10; d++) begin
                tick();
                if (get_start(sel) !== 1'b0) start_ok = 1'b0;
                if (get_data(sel) !== eb) hold_ok = 1'b0;
                if (get_fd(sel) !== 1'b0) fd_ok = 1'b0;
            end
            set_done(sel, 1'b1);
            tick();
            set_done(sel, 1'b0);
        end
        chk("start_one_cycle", start_ok, 1'b1);
        chk("data_held", hold_ok, 1'b1);
        chk("no_early_frame_done", fd_ok, 1'b1);
        if (nbytes == 16) begin
            chk("frame_done_at_end", get_fd(sel), last);
            chk("blocks_sent", get_cnt(sel), 16'(exp_cnt));
            tick();
            chk("frame_done_one_cycle", get_fd(sel), 1'b0);
        end
    endtask

    initial begin
        int  acc;
        bit  rdy;

        reset   = 1'b0;
        a_data  = '0; b_data = '0;
        a_last  = 1'b0; b_last = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0;
        a_done  = 1'b0; b_done = 1'b0;

        // 1. Reset held 3 cycles with valid offered and done pulsing
        tick();
        a_valid = 1'b1; b_valid = 1'b1; a_data = BLK; b_data = BLK;
        for (int c = 0; c < 3; c++) begin
            a_done = c[0] ? 1'b0 : 1'b1;
            b_done = a_done;
            tick();
        end
        chk("rst_ready", a_ready, 1'b1);
        chk("rst_start", a_start, 1'b0);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_count", a_cnt, 16'd0);
        chk("rst_frame_done", a_fd, 1'b0);
        chk("rst_data", a_txd, 8'h00);
        a_valid = 1'b0; b_valid = 1'b0; a_done = 1'b0; b_done = 1'b0;
        reset = 1'b1;
        tick();
        chk("rst_no_push_a", a_busy, 1'b0);
        chk("rst_no_push_b", b_busy, 1'b0);
        chk("rst_start_after", a_start, 1'b0);

        // 2. Single block, LSB first
        push(1'b0, BLK, 1'b1);
        serve_block(1'b0, BLK, 1'b1, 1'b1, 1'b0, 16, 1);
        chk("idle_after_single", a_busy, 1'b0);

        // 3. MSB first, start latency from the accepting edge
        push(1'b1, BLK, 1'b1);
        chk("msb_no_start_yet", b_start, 1'b0);
        chk("msb_busy", b_busy, 1'b1);
        tick();
        chk("msb_start_2cyc", b_start, 1'b1);
        serve_block(1'b1, BLK, 1'b1, 1'b0, 1'b0, 16, 1);

        // 4. Back-pressure: four blocks offered, done withheld
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            a_valid = 1'b1; a_last = 1'b0; a_data = mk(acc);
            rdy = a_ready;
            tick();
            if (rdy) acc++;
            if (acc == 4) break;
        end
        chk("bp_accepted", acc, 3);
        chk("bp_ready_low", a_ready, 1'b0);
        a_data = mk(3);
        serve_block(1'b0, mk(0), 1'b0, 1'b1, 1'b1, 16, 2);
        chk("bp_ready_reopen", a_ready, 1'b1);
        tick();
        a_valid = 1'b0;
        serve_block(1'b0, mk(1), 1'b0, 1'b1, 1'b1, 16, 3);
        serve_block(1'b0, mk(2), 1'b0, 1'b1, 1'b0, 16, 4);
        serve_block(1'b0, mk(3), 1'b0, 1'b1, 1'b0, 16, 5);
        chk("bp_drained", a_busy, 1'b0);

        // 5. Stray done in idle, then reset in the middle of a block
        a_done = 1'b1;
        tick();
        a_done = 1'b0;
        chk("stray_start", a_start, 1'b0);
        tick();
        chk("stray_start2", a_start, 1'b0);
        chk("stray_count", a_cnt, 16'd5);
        chk("stray_busy", a_busy, 1'b0);
        push(1'b0, mk(5), 1'b1);
        serve_block(1'b0, mk(5), 1'b1, 1'b1, 1'b0, 5, 0);
        chk("mid_busy", a_busy, 1'b1);
        reset = 1'b0;
        tick();
        chk("mid_rst_ready", a_ready, 1'b1);
        chk("mid_rst_start", a_start, 1'b0);
        chk("mid_rst_data", a_txd, 8'h00);
        chk("mid_rst_busy", a_busy, 1'b0);
        chk("mid_rst_fd", a_fd, 1'b0);
        chk("mid_rst_count", a_cnt, 16'd0);
        reset  = 1'b1;
        a_done = 1'b1;
        tick();
        a_done = 1'b0;
        chk("late_done_start", a_start, 1'b0);
        tick();
        chk("late_done_busy", a_busy, 1'b0);
        chk("late_done_count", a_cnt, 16'd0);
        push(1'b0, mk(9), 1'b0);
        serve_block(1'b0, mk(9), 1'b0, 1'b1, 1'b0, 16, 1);

        // 6. Frame marking over three blocks
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        push(1'b0, mk(6), 1'b0);
        push(1'b0, mk(7), 1'b0);
        push(1'b0, mk(8), 1'b1);
        serve_block(1'b0, mk(6), 1'b0, 1'b1, 1'b1, 16, 1);
        serve_block(1'b0, mk(7), 1'b0, 1'b1, 1'b0, 16, 2);
        serve_block(1'b0, mk(8), 1'b1, 1'b1, 1'b0, 16, 3);
        chk("frame_idle", a_busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
